// File: rtl/dmem_if.sv
// Request/response bus between the pipeline's data-memory port and its memory responder.
interface dmem_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_wr;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic [DATA_WIDTH/8-1:0] req_be;
  logic                    resp_valid;
  logic [DATA_WIDTH-1:0]   resp_rdata;
  logic                    resp_err;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, req_be,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, req_be,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data memory with byte-enable stores, valid/ready request handshake and a
// single-cycle response pulse after WAIT_STATES extra cycles.
module dmem_responder #(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input logic   clk,
  input logic   rst,
  dmem_if.slave bus
);
  localparam int unsigned NumBytes = DATA_WIDTH / 8;
  localparam int unsigned IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam bit          NoWait   = (WAIT_STATES == 0);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [NumBytes-1:0]   be_q, be_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic                  resp_err_q, resp_err_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  accept;
  logic                  do_access;
  logic                  acc_wr;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic [NumBytes-1:0]   acc_be;
  logic [IdxW-1:0]       acc_idx;
  logic                  in_range;

  assign bus.req_ready  = (state_q == StIdle);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

  always_comb begin
    accept    = bus.req_valid && bus.req_ready;
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    do_access = 1'b0;
    acc_wr    = wr_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_be    = be_q;

    if (NoWait) begin
      // Zero wait states: the access happens on the acceptance edge, straight from the bus.
      if (accept) begin
        do_access = 1'b1;
        acc_wr    = bus.req_wr;
        acc_addr  = bus.req_addr;
        acc_wdata = bus.req_wdata;
        acc_be    = bus.req_be;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_d = StBusy;
            cnt_d   = 4'(WAIT_STATES);
            wr_d    = bus.req_wr;
            addr_d  = bus.req_addr;
            wdata_d = bus.req_wdata;
            be_d    = bus.req_be;
          end
        end
        StBusy: begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            do_access = 1'b1;
            state_d   = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    acc_idx      = acc_addr[IdxW-1:0];
    in_range     = (acc_addr < ADDR_WIDTH'(DEPTH));
    resp_valid_d = do_access;
    resp_err_d   = do_access && !in_range;
    resp_rdata_d = '0;
    if (do_access && in_range && !acc_wr) begin
      resp_rdata_d = mem_q[acc_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Array is never reset; reset only suppresses a store that would commit on this edge.
  always_ff @(posedge clk) begin
    if (!rst && do_access && acc_wr && in_range) begin
      for (int i = 0; i < NumBytes; i++) begin
        if (acc_be[i]) begin
          mem_q[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
        end
      end
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance with no wait states, one with three, both checked
// every cycle against a transaction-level memory model plus literal spot checks.
module tb_dmem_responder;
  logic clk;
  logic rst0;
  logic rst3;
  int   cyc;
  int   total;
  int   passed;

  dmem_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) b0 ();
  dmem_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) b3 ();

  dmem_responder #(
    .DATA_WIDTH(64), .ADDR_WIDTH(32), .DEPTH(256), .WAIT_STATES(0)
  ) u_dut0 (
    .clk (clk),
    .rst (rst0),
    .bus (b0)
  );

  dmem_responder #(
    .DATA_WIDTH(64), .ADDR_WIDTH(32), .DEPTH(256), .WAIT_STATES(3)
  ) u_dut3 (
    .clk (clk),
    .rst (rst3),
    .bus (b3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: expected responses keyed by (instance, cycle), memory keyed by (instance, addr).
  typedef struct packed {
    logic [63:0] d;
    logic        err;
    logic        known;
  } resp_t;

  resp_t       sched [longint];
  logic [63:0] mmem  [longint];
  int          busy_end [2] = '{-1, -1};
  bit          pend_v   [2];
  int          pend_c   [2];
  logic [31:0] pend_a   [2];
  logic [63:0] pend_wd  [2];
  logic [7:0]  pend_be  [2];

  function automatic longint key(input int d, input int c);
    return (longint'(d) << 32) + longint'(c);
  endfunction

  function automatic longint mkey(input int d, input logic [31:0] a);
    return (longint'(d) << 32) + longint'(a);
  endfunction

  task automatic commit(input int d, input logic [31:0] a, input logic [63:0] wd,
                        input logic [7:0] be);
    logic [63:0] w;
    if (!mmem.exists(mkey(d, a)) && be != 8'hFF) return;
    w = mmem.exists(mkey(d, a)) ? mmem[mkey(d, a)] : 64'h0;
    for (int i = 0; i < 8; i++) if (be[i]) w[8*i +: 8] = wd[8*i +: 8];
    mmem[mkey(d, a)] = w;
  endtask

  task automatic step(input int d, input int n, input bit r, input bit v, input bit w,
                      input logic [31:0] a, input logic [63:0] wd, input logic [7:0] be,
                      input int c);
    resp_t e;
    if (r) begin
      pend_v[d]   = 1'b0;
      busy_end[d] = c;
      for (int j = 1; j <= 17; j++) if (sched.exists(key(d, c + j))) sched.delete(key(d, c + j));
    end else begin
      if (pend_v[d] && pend_c[d] == c) begin
        commit(d, pend_a[d], pend_wd[d], pend_be[d]);
        pend_v[d] = 1'b0;
      end
      if (v && c > busy_end[d]) begin
        e.d     = 64'h0;
        e.err   = 1'b0;
        e.known = 1'b1;
        if (a >= 32'd256) begin
          e.err = 1'b1;
        end else if (!w) begin
          if (mmem.exists(mkey(d, a))) e.d = mmem[mkey(d, a)];
          else e.known = 1'b0;
        end else if (n == 0) begin
          commit(d, a, wd, be);
        end else begin
          pend_v[d]  = 1'b1;
          pend_c[d]  = c + n;
          pend_a[d]  = a;
          pend_wd[d] = wd;
          pend_be[d] = be;
        end
        sched[key(d, c + n + 1)] = e;
        busy_end[d] = c + n;
      end
    end
  endtask

  always @(posedge clk) begin
    step(0, 0, rst0, b0.req_valid, b0.req_wr, b0.req_addr, b0.req_wdata, b0.req_be, cyc);
    step(1, 3, rst3, b3.req_valid, b3.req_wr, b3.req_addr, b3.req_wdata, b3.req_be, cyc);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic cmp(input int d, input logic rdy, input logic v, input logic [63:0] rd,
                     input logic er);
    resp_t e;
    bit    ev;
    ev = sched.exists(key(d, cyc));
    if (ev) e = sched[key(d, cyc)];
    else begin
      e.d     = 64'h0;
      e.err   = 1'b0;
      e.known = 1'b1;
    end
    chk($sformatf("dut%0d req_ready", d), 64'(rdy), 64'(cyc > busy_end[d]));
    chk($sformatf("dut%0d resp_valid", d), 64'(v), 64'(ev));
    chk($sformatf("dut%0d resp_err", d), 64'(er), 64'(e.err));
    if (e.known) chk($sformatf("dut%0d resp_rdata", d), rd, e.d);
  endtask

  always @(negedge clk) begin
    if (cyc >= 1) begin
      cmp(0, b0.req_ready, b0.resp_valid, b0.resp_rdata, b0.resp_err);
      cmp(1, b3.req_ready, b3.resp_valid, b3.resp_rdata, b3.resp_err);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int d, input bit v, input bit w, input logic [31:0] a,
                     input logic [63:0] wd, input logic [7:0] be);
    if (d == 0) begin
      b0.req_valid = v;
      b0.req_wr    = w;
      b0.req_addr  = a;
      b0.req_wdata = wd;
      b0.req_be    = be;
    end else begin
      b3.req_valid = v;
      b3.req_wr    = w;
      b3.req_addr  = a;
      b3.req_wdata = wd;
      b3.req_be    = be;
    end
  endtask

  initial begin
    total  = 0;
    passed = 0;
    rst0   = 1'b1;
    rst3   = 1'b1;
    drv(0, 1'b0, 1'b0, 32'h0, 64'h0, 8'h0);
    drv(1, 1'b0, 1'b0, 32'h0, 64'h0, 8'h0);
    tick();
    tick();
    chk("reset ready", 64'(b0.req_ready), 64'h1);
    chk("reset valid", 64'(b0.resp_valid), 64'h0);
    chk("reset rdata", b0.resp_rdata, 64'h0);
    chk("reset err", 64'(b3.resp_err), 64'h0);
    rst0 = 1'b0;
    rst3 = 1'b0;
    tick();
    tick();

    // No wait states: store then load back-to-back.
    drv(0, 1'b1, 1'b1, 32'd5, 64'h1122_3344_5566_7788, 8'hFF);
    tick();
    drv(0, 1'b1, 1'b0, 32'd5, 64'h0, 8'h0);
    tick();
    drv(0, 1'b0, 1'b0, 32'h0, 64'h0, 8'h0);
    chk("b2b load valid", 64'(b0.resp_valid), 64'h1);
    chk("b2b load rdata", b0.resp_rdata, 64'h1122_3344_5566_7788);
    chk("b2b load err", 64'(b0.resp_err), 64'h0);
    tick();

    // Byte enables.
    drv(0, 1'b1, 1'b1, 32'd7, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    tick();
    drv(0, 1'b1, 1'b1, 32'd7, 64'h0, 8'h0F);
    tick();
    drv(0, 1'b1, 1'b0, 32'd7, 64'h0, 8'h0);
    tick();
    drv(0, 1'b0, 1'b0, 32'h0, 64'h0, 8'h0);
    chk("be load rdata", b0.resp_rdata, 64'hFFFF_FFFF_0000_0000);
    tick();

    // Out of range store and load, then confirm mem[5] untouched; be=0 store is a no-op.
    drv(0, 1'b1, 1'b1, 32'd256, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF);
    tick();
    drv(0, 1'b1, 1'b0, 32'h8000_0005, 64'h0, 8'h0);
    chk("oor store err", 64'(b0.resp_err), 64'h1);
    chk("oor store rdata", b0.resp_rdata, 64'h0);
    tick();
    drv(0, 1'b1, 1'b1, 32'd5, 64'hCAFE_CAFE_CAFE_CAFE, 8'h00);
    chk("oor load err", 64'(b0.resp_err), 64'h1);
    chk("oor load rdata", b0.resp_rdata, 64'h0);
    tick();
    drv(0, 1'b1, 1'b0, 32'd5, 64'h0, 8'h0);
    tick();
    drv(0, 1'b0, 1'b0, 32'h0, 64'h0, 8'h0);
    chk("mem5 intact", b0.resp_rdata, 64'h1122_3344_5566_7788);
    tick();

    // Three wait states: preload addr 9, then load with req_valid held while busy.
    drv(1, 1'b1, 1'b1, 32'd9, 64'hA5A5_A5A5_A5A5_A5A5, 8'hFF);
    tick();
    drv(1, 1'b0, 1'b0, 32'h0, 64'h0, 8'h0);
    repeat (4) tick();
    drv(1, 1'b1, 1'b0, 32'd9, 64'h0, 8'h0);
    tick();
    chk("ws3 busy ready", 64'(b3.req_ready), 64'h0);
    tick();
    tick();
    chk("ws3 no early resp", 64'(b3.resp_valid), 64'h0);
    drv(1, 1'b0, 1'b0, 32'h0, 64'h0, 8'h0);
    tick();
    chk("ws3 resp valid", 64'(b3.resp_valid), 64'h1);
    chk("ws3 resp ready", 64'(b3.req_ready), 64'h1);
    chk("ws3 resp rdata", b3.resp_rdata, 64'hA5A5_A5A5_A5A5_A5A5);
    tick();

    // Reset while busy with a store: no response, store discarded.
    drv(1, 1'b1, 1'b1, 32'd9, 64'h0123_4567_89AB_CDEF, 8'hFF);
    tick();
    drv(1, 1'b0, 1'b0, 32'h0, 64'h0, 8'h0);
    rst3 = 1'b1;
    tick();
    rst3 = 1'b0;
    repeat (3) tick();
    chk("aborted no resp", 64'(b3.resp_valid), 64'h0);
    tick();
    drv(1, 1'b1, 1'b0, 32'd9, 64'h0, 8'h0);
    tick();
    drv(1, 1'b0, 1'b0, 32'h0, 64'h0, 8'h0);
    repeat (3) tick();
    chk("aborted store rdata", b3.resp_rdata, 64'hA5A5_A5A5_A5A5_A5A5);
    repeat (3) tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder for the pipeline's data-memory port. The pipeline initiates word-addressed load/store requests; this block accepts them through a valid/ready handshake and commits stores with byte enables. It returns load data through a one-cycle response pulse after a parameterisable number of wait states. It sits outside the pipeline, in the testbench/SoC wrapper, and is the memory end of the dmem address/data-in/data-out interface.

Parameters:
DATA_WIDTH, 64, width of one memory word and of the read/write data buses
ADDR_WIDTH, 32, width of the request address (word address)
DEPTH, 256, number of words stored; valid addresses are 0..DEPTH-1
WAIT_STATES, 0, extra cycles between request acceptance and the response (0..15)

Ports:
clk  input  1  clock; all state changes on the rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  1  request present this cycle
req_ready  output  1  responder can accept a request this cycle
req_wr  input  1  1 = store, 0 = load
req_addr  input  ADDR_WIDTH  word address
req_wdata  input  DATA_WIDTH  store data
req_be  input  DATA_WIDTH/8  store byte enables; bit i covers bits [8i+7:8i]
resp_valid  output  1  one-cycle response pulse
resp_rdata  output  DATA_WIDTH  load data; 0 for stores and errors
resp_err  output  1  address out of range; qualified by resp_valid

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, wait counter=0, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0. Memory array contents are not reset.
- Reset mid-operation aborts any BUSY request. A pending store is not committed. No response is produced.
- Handshake: a request is accepted at an edge where req_valid && req_ready. All request fields are captured at acceptance. The requester may change its inputs from the next cycle on.
- States: IDLE (req_ready=1) and BUSY (req_ready=0). No backpressure on the response: resp_valid is high for exactly one cycle.
- WAIT_STATES=0: the access is performed at the acceptance edge. The response is visible in the following cycle. The state stays IDLE, so one request per cycle is sustained.
- WAIT_STATES=N>0: at acceptance, go to BUSY and load the counter with N. Decrement the counter at each BUSY edge.
- At the edge where the counter goes 1->0, perform the access, register the response and return to IDLE.
- Response latency: visible N+1 cycles after the acceptance cycle.
- A new request may be accepted in the response cycle.
- Access, in range (req_addr < DEPTH):
  - Load: resp_rdata = mem[addr], resp_err=0.
  - Store: for each i with be[i]=1, write byte i of mem[addr]; bytes with be[i]=0 are unchanged; resp_rdata=0, resp_err=0.
  - Store with be=0: no change, normal response.
- Access, out of range (req_addr >= DEPTH, including any set upper bits): no write, resp_rdata=0, resp_err=1.
- Ordering: requests complete in acceptance order. A load accepted after a store to the same address returns the stored data, including back-to-back at WAIT_STATES=0.
- Outputs in non-response cycles: resp_valid=0, and resp_rdata/resp_err are held at 0.
- req_valid is ignored while BUSY; it is neither counted nor queued.

Test Plan:
- Reset then idle, WAIT_STATES=0: hold rst 2 cycles -> req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0 every cycle.
- WAIT_STATES=0 back-to-back: store addr 5, data 0x1122334455667788, be=0xFF; next cycle load addr 5 -> one response per cycle. The load response returns 0x1122334455667788 in the cycle after the load is accepted, resp_err=0.
- Byte enables: mem[7]=0xFFFF_FFFF_FFFF_FFFF; store 0 with be=0x0F; load 7 -> 0xFFFF_FFFF_0000_0000.
- WAIT_STATES=3: load accepted in cycle t -> req_ready=0 in t+1..t+3 while req_valid stays high and is ignored. resp_valid=1 only in cycle t+4. req_ready=1 in t+4.
- Out of range, DEPTH=256: store addr 256 then load addr 0x8000_0005 -> both responses have resp_err=1 and resp_rdata=0. mem[5] is unchanged when read at addr 5.
- Reset mid-BUSY, WAIT_STATES=3: store to addr 9 accepted, rst asserted 1 cycle later -> no resp_valid. A later load of addr 9 returns the pre-store value.
